// File: rtl/unpack_leb128_stream_if.sv
// ============================================================================
// Module      : unpack_leb128_stream_if
// Description : Byte-in / result-out handshake bundle for the LEB128 unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface unpack_leb128_stream_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         signed_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   out_len;
    logic         out_err;

    modport master (
        output in_valid, in_data, signed_mode, out_ready,
        input  in_ready, out_valid, out_data, out_len, out_err
    );

    modport slave (
        input  in_valid, in_data, signed_mode, out_ready,
        output in_ready, out_valid, out_data, out_len, out_err
    );
endinterface

`default_nettype wire

// File: rtl/unpack_leb128_stream.sv
// ============================================================================
// Module      : unpack_leb128_stream
// Description : Streaming ULEB128/SLEB128 decoder, one byte per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unpack_leb128_stream #(
    parameter int W = 64
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    unpack_leb128_stream_if.slave bus
);
    localparam int         N      = (W + 6) / 7;
    localparam logic [3:0] C_LAST = 4'(N - 1);

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t       r_state;
    logic [3:0]   r_k;
    logic [W-1:0] r_acc;
    logic         r_signed;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic [3:0]   r_out_len;
    logic         r_out_err;

    logic         w_in_ready;
    logic         w_in_fire;
    logic [6:0]   w_shift;
    logic [6:0]   w_shift_end;
    logic [W-1:0] w_acc_next;
    logic         w_signed_eff;
    logic [W-1:0] w_sext;
    logic [3:0]   w_k_sat;

    // Gating with rst_n keeps in_ready low for the whole time reset is held.
    assign w_in_ready   = rst_n & (r_state != ST_OUT);
    assign w_in_fire    = bus.in_valid & w_in_ready;
    assign w_shift      = 7'(r_k) * 7'd7;
    assign w_shift_end  = w_shift + 7'd7;
    assign w_acc_next   = r_acc | (W'(bus.in_data[6:0]) << w_shift);
    assign w_signed_eff = (r_k == 4'd0) ? bus.signed_mode : r_signed;
    // A shift of W or more yields zero, so the last legal byte never extends.
    assign w_sext       = (w_signed_eff & bus.in_data[6]) ? ({W{1'b1}} << w_shift_end) : '0;
    assign w_k_sat      = (r_k == 4'd15) ? 4'd15 : r_k + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACC;
            r_k         <= 4'd0;
            r_acc       <= '0;
            r_signed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_len   <= 4'd0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_in_fire) begin
                        r_k   <= w_k_sat;
                        r_acc <= w_acc_next;
                        if (r_k == 4'd0) begin
                            r_signed <= bus.signed_mode;
                        end
                        if (!bus.in_data[7]) begin
                            r_state     <= ST_OUT;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_acc_next | w_sext;
                            r_out_len   <= r_k + 4'd1;
                            r_out_err   <= 1'b0;
                        end else if (r_k == C_LAST) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (w_in_fire) begin
                        r_k <= w_k_sat;
                        if (!bus.in_data[7]) begin
                            r_state     <= ST_OUT;
                            r_out_valid <= 1'b1;
                            r_out_data  <= r_acc;
                            r_out_len   <= w_k_sat;
                            r_out_err   <= 1'b1;
                        end
                    end
                end

                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_ACC;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_k         <= 4'd0;
                    end
                end

                default: begin
                    r_state <= ST_ACC;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_len   = r_out_len;
    assign bus.out_err   = r_out_err;

endmodule

`default_nettype wire
